// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg: shared state encoding and default widths for the fetch redirect controller
package pc_redirect_ctrl_pkg;
   localparam int PC_W_DEF  = 16;
   localparam int CNT_W_DEF = 16;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PEND = 2'b01,
      HALT = 2'b10
   } state_t;
endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: decode/hazard/fetch signal bundle around the redirect controller
// master: decode PC logic, hazard unit and fetch (drive decode inputs, observe redirect outputs)
// slave:  pc_redirect_ctrl (consumes decode inputs, drives redirect/flush/hold/debug outputs)
interface pc_redirect_ctrl_if
   import pc_redirect_ctrl_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             Dec_Valid;
   logic             Dec_Stall;
   logic             PC_Sel;
   logic [PC_W-1:0]  PC_Ex;
   logic             Halt;
   logic             Fetch_Busy;
   logic             Redirect_Valid;
   logic [PC_W-1:0]  Redirect_PC;
   logic             Flush_IFID;
   logic             PC_Hold;
   logic             Halted;
   logic [CNT_W-1:0] Redirect_Count;
   modport master (
      output Dec_Valid, Dec_Stall, PC_Sel, PC_Ex, Halt, Fetch_Busy,
      input  Redirect_Valid, Redirect_PC, Flush_IFID, PC_Hold, Halted, Redirect_Count
   );
   modport slave (
      input  Dec_Valid, Dec_Stall, PC_Sel, PC_Ex, Halt, Fetch_Busy,
      output Redirect_Valid, Redirect_PC, Flush_IFID, PC_Hold, Halted, Redirect_Count
   );
endinterface

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
// clk/rst_n: clock, async active-low reset; inc: count enable; count: current value
module sat_counter
   import pc_redirect_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;
   always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   assign count = count_q;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: registers decode-stage redirects, holds them until fetch accepts, freezes on HALT
// clk/rst_n: clock, async active-low reset
// bus (slave): Dec_Valid/Dec_Stall/PC_Sel/PC_Ex/Halt/Fetch_Busy in;
//              Redirect_Valid/Redirect_PC/Flush_IFID/PC_Hold/Halted/Redirect_Count out
module pc_redirect_ctrl
   import pc_redirect_ctrl_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pc_redirect_ctrl_if.slave    bus
);
   state_t           state_q, state_d;
   logic [PC_W-1:0]  target_q, target_d;
   logic             fire, inc;
   logic [CNT_W-1:0] count;
   assign fire = bus.Dec_Valid && !bus.Dec_Stall;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   // Halt wins over PC_Sel; once in PEND or HALT the decode inputs are wrong-path and ignored
   always_comb begin
      state_d  = (state_q == IDLE && fire) ? (bus.Halt ? HALT : bus.PC_Sel ? PEND : IDLE) :
                 (state_q == PEND && !bus.Fetch_Busy) ? IDLE : state_q;
      target_d = (state_q == IDLE && fire && !bus.Halt && bus.PC_Sel) ? bus.PC_Ex : target_q;
   end
   // Combinational outputs are masked by rst_n so they read 0 for the whole reset pulse
   always_comb begin
      bus.Redirect_Valid = rst_n && state_q == PEND;
      bus.Flush_IFID     = rst_n && (state_q != IDLE || (fire && (bus.Halt || bus.PC_Sel)));
      bus.PC_Hold        = rst_n && (state_q == HALT || (state_q == PEND && bus.Fetch_Busy));
      bus.Halted         = rst_n && state_q == HALT;
      bus.Redirect_PC    = target_q;
      bus.Redirect_Count = count;
   end
   assign inc = state_q == PEND && !bus.Fetch_Busy;
   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc),
      .count (count)
   );
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: randomized and directed check of pc_redirect_ctrl against a behavioural model
module tb_pc_redirect_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dv = 1'b0, ds = 1'b0, sel = 1'b0, h = 1'b0, fb = 1'b0;
   logic [15:0] ex = '0;
   int          checks = 0, errors = 0;
   bit          run = 1'b0;

   always #5 clk = ~clk;

   pc_redirect_ctrl_if #(.PC_W(16), .CNT_W(16)) ia ();
   pc_redirect_ctrl_if #(.PC_W(16), .CNT_W(2))  ib ();

   assign ia.Dec_Valid = dv;  assign ib.Dec_Valid = dv;
   assign ia.Dec_Stall = ds;  assign ib.Dec_Stall = ds;
   assign ia.PC_Sel = sel;    assign ib.PC_Sel = sel;
   assign ia.PC_Ex = ex;      assign ib.PC_Ex = ex;
   assign ia.Halt = h;        assign ib.Halt = h;
   assign ia.Fetch_Busy = fb; assign ib.Fetch_Busy = fb;

   pc_redirect_ctrl #(.PC_W(16), .CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(ia));
   pc_redirect_ctrl #(.PC_W(16), .CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(ib));

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // Behavioural model: a pending redirect, a halted flag, the last captured target and a plain integer count
   bit          m_pend = 1'b0, m_halt = 1'b0;
   logic [15:0] m_tgt = '0;
   int          m_cnt = 0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_pend = 1'b0; m_halt = 1'b0; m_tgt = '0; m_cnt = 0;
      end else if (!m_halt) begin
         if (m_pend) begin
            if (!fb) begin m_pend = 1'b0; m_cnt++; end
         end else if (dv && !ds && h) m_halt = 1'b1;
         else if (dv && !ds && sel) begin m_pend = 1'b1; m_tgt = ex; end
      end

   always @(negedge clk) begin : cmp
      logic live, fire;
      logic [15:0] c16;
      logic [1:0]  c2;
      if (run) begin
         live = rst_n;
         fire = dv && !ds;
         c16 = m_cnt > 65535 ? 16'hffff : 16'(m_cnt);
         c2  = m_cnt > 3 ? 2'd3 : 2'(m_cnt);
         chk("valid",  ia.Redirect_Valid, live && m_pend);
         chk("flush",  ia.Flush_IFID, live && (m_halt || m_pend || (fire && (h || sel))));
         chk("hold",   ia.PC_Hold, live && (m_halt || (m_pend && fb)));
         chk("halted", ia.Halted, live && m_halt);
         chk("pc",     ia.Redirect_PC, m_tgt);
         chk("count",  ia.Redirect_Count, c16);
         chk("count2", ib.Redirect_Count, c2);
         chk("pc2",    ib.Redirect_PC, ia.Redirect_PC);
      end
   end

   task automatic go(input logic r, v, s, p, input logic [15:0] e, input logic hh, f);
      @(posedge clk);
      #1;
      rst_n = r; dv = v; ds = s; sel = p; ex = e; h = hh; fb = f;
      @(negedge clk);
   endtask

   initial begin
      dv = 1'b1; sel = 1'b1; ex = 16'h0055;
      run = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_flush", ia.Flush_IFID, 0);
      chk("rst_valid", ia.Redirect_Valid, 0);
      chk("rst_pc", ia.Redirect_PC, 0);
      chk("rst_count", ia.Redirect_Count, 0);
      go(1, 0, 0, 0, 0, 0, 0);
      chk("idle_count", ia.Redirect_Count, 0);
      chk("idle_pc", ia.Redirect_PC, 0);
      // simple redirect
      go(1, 1, 0, 1, 16'h0040, 0, 0);
      chk("sr_flush", ia.Flush_IFID, 1);
      chk("sr_valid0", ia.Redirect_Valid, 0);
      go(1, 0, 0, 0, 0, 0, 0);
      chk("sr_valid1", ia.Redirect_Valid, 1);
      chk("sr_pc", ia.Redirect_PC, 16'h0040);
      go(1, 0, 0, 0, 0, 0, 0);
      chk("sr_valid2", ia.Redirect_Valid, 0);
      chk("sr_count", ia.Redirect_Count, 1);
      // fetch busy, with a wrong-path PC_Sel while pending
      go(1, 1, 0, 1, 16'h1234, 0, 1);
      chk("fb_flush", ia.Flush_IFID, 1);
      repeat (3) begin
         go(1, 1, 0, 1, 16'h9999, 0, 1);
         chk("fb_valid", ia.Redirect_Valid, 1);
         chk("fb_hold", ia.PC_Hold, 1);
         chk("fb_pc", ia.Redirect_PC, 16'h1234);
      end
      go(1, 0, 0, 0, 0, 0, 0);
      chk("fb_accept_valid", ia.Redirect_Valid, 1);
      chk("fb_accept_hold", ia.PC_Hold, 0);
      go(1, 0, 0, 0, 0, 0, 0);
      chk("fb_done_valid", ia.Redirect_Valid, 0);
      chk("fb_count", ia.Redirect_Count, 2);
      chk("fb_pc_kept", ia.Redirect_PC, 16'h1234);
      // stall gating
      repeat (2) begin
         go(1, 1, 1, 1, 16'h0100, 0, 0);
         chk("st_flush", ia.Flush_IFID, 0);
         chk("st_valid", ia.Redirect_Valid, 0);
      end
      go(1, 1, 0, 1, 16'h0100, 0, 0);
      chk("st_fire_flush", ia.Flush_IFID, 1);
      go(1, 0, 0, 0, 0, 0, 0);
      chk("st_valid1", ia.Redirect_Valid, 1);
      chk("st_pc", ia.Redirect_PC, 16'h0100);
      go(1, 0, 0, 0, 0, 0, 0);
      chk("st_count", ia.Redirect_Count, 3);
      // halt beats PC_Sel, then everything is ignored
      go(1, 1, 0, 1, 16'h2222, 1, 0);
      chk("h_flush", ia.Flush_IFID, 1);
      chk("h_halted0", ia.Halted, 0);
      repeat (3) begin
         go(1, 1, 0, 1, 16'h3333, 0, 0);
         chk("h_halted", ia.Halted, 1);
         chk("h_hold", ia.PC_Hold, 1);
         chk("h_valid", ia.Redirect_Valid, 0);
         chk("h_count", ia.Redirect_Count, 3);
         chk("h_pc", ia.Redirect_PC, 16'h0100);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("ar_halted", ia.Halted, 0);
      chk("ar_hold", ia.PC_Hold, 0);
      chk("ar_flush", ia.Flush_IFID, 0);
      chk("ar_count", ia.Redirect_Count, 0);
      chk("ar_pc", ia.Redirect_PC, 0);
      dv = 1'b0; sel = 1'b0;
      #1 rst_n = 1'b1;
      // saturation on the 2-bit counter instance
      for (int i = 0; i < 5; i++) begin
         go(1, 1, 0, 1, 16'(16'h0010 + i), 0, 0);
         go(1, 0, 0, 0, 0, 0, 0);
         go(1, 0, 0, 0, 0, 0, 0);
         chk("sat_count2", ib.Redirect_Count, (i + 1 > 3) ? 3 : i + 1);
         chk("sat_count16", ia.Redirect_Count, i + 1);
      end
      // randomized traffic
      for (int i = 0; i < 1500; i++)
         go($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)));
      go(1, 0, 0, 0, 0, 0, 0);
      run = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences fetch-stage redirects produced by the decode-stage PC logic (PC_Sel / PC_Ex).
- Registers the taken target and holds it until instruction memory accepts it.
- Squashes wrong-path IF/ID contents and freezes the PC permanently on HALT.
- Sits between decode PC logic, the hazard unit and the fetch PC mux; keeps a saturating count of taken redirects for debug.

Parameters:
PC_W, 16, width of PC and target address
CNT_W, 16, width of redirect counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
Dec_Valid  input  1  decode stage holds a valid instruction
Dec_Stall  input  1  hazard unit stalling decode; PC_Sel/PC_Ex not final
PC_Sel  input  1  decode PC logic requests jump/taken branch
PC_Ex  input  PC_W  redirect target from decode PC logic
Halt  input  1  decode instruction is HALT
Fetch_Busy  input  1  instruction memory cannot accept a new address this cycle
Redirect_Valid  output  1  fetch must load Redirect_PC this cycle
Redirect_PC  output  PC_W  target for fetch PC mux
Flush_IFID  output  1  squash IF/ID latch input this cycle
PC_Hold  output  1  fetch PC must not advance
Halted  output  1  processor halted
Redirect_Count  output  CNT_W  number of redirects accepted by fetch, saturating

Behaviour:
- States: IDLE, PEND, HALT.
- Reset (rst_n=0, async):
  - state=IDLE, target_q=0, count=0.
  - All outputs 0, including combinational ones, while rst_n=0.
- Define fire = Dec_Valid & ~Dec_Stall.
- IDLE:
  - fire & Halt -> HALT next cycle. Halt has priority over PC_Sel in the same cycle. Flush_IFID=1 this cycle.
  - fire & PC_Sel & ~Halt -> target_q<=PC_Ex, go to PEND. Flush_IFID=1 this cycle; Redirect_Valid=0 this cycle.
  - Otherwise all outputs 0.
- PEND:
  - Redirect_Valid=1, Redirect_PC=target_q, Flush_IFID=1 every cycle.
  - PC_Hold=Fetch_Busy.
  - ~Fetch_Busy -> IDLE next cycle; count increments, saturating at all-ones.
  - Fetch_Busy -> remain in PEND; target_q stable.
  - Decode inputs (Dec_Valid, PC_Sel, Halt) are ignored; they are wrong-path.
- HALT:
  - PC_Hold=1, Halted=1, Flush_IFID=1, Redirect_Valid=0.
  - Leaves only via reset; all inputs ignored.
- Redirect_PC=target_q in every state (0 after reset). Consumers qualify it with Redirect_Valid.
- Latency:
  - Target presented to fetch 1 cycle after the decode fire.
  - Minimum 2 cycles decode-fire to back-to-back fire capability (IDLE->PEND->IDLE).
- Dec_Stall=1: no capture, even if PC_Sel=1; no flush.
- Reset asserted in PEND: pending target discarded, count preserved only if not reset (count is reset).
- PC_Ex width PC_W, passed unmodified; no arithmetic on target.

Decomposition:
- Shared package/header:
  - State encodings IDLE=2'b00, PEND=2'b01, HALT=2'b10.
  - PC_W default 16.
- One sub-module: sat_counter (CNT_W, async active-low reset, inc, count out, holds at all-ones).

Test Plan:
- Reset check: rst_n=0 with Dec_Valid=PC_Sel=1 -> all outputs 0. Release, idle inputs -> Redirect_Count=0, Redirect_PC=0x0000.
- Simple redirect:
  - Cycle 0: fire, PC_Sel=1, PC_Ex=0x0040, Fetch_Busy=0 -> cycle 0 Flush_IFID=1.
  - Cycle 1: Redirect_Valid=1, Redirect_PC=0x0040.
  - Cycle 2: Redirect_Valid=0, Redirect_Count=1.
- Fetch busy:
  - Redirect to 0x1234 with Fetch_Busy=1 for 3 cycles -> Redirect_Valid=1, PC_Hold=1 for 3 cycles, Redirect_PC stays 0x1234.
  - 4th cycle: Fetch_Busy=0 -> accepted, count+1.
  - A PC_Sel with PC_Ex=0x9999 during PEND is ignored.
- Stall gating: Dec_Stall=1, PC_Sel=1, PC_Ex=0x0100 for 2 cycles -> no flush, no capture. Dec_Stall drops -> capture 0x0100 next edge.
- Halt:
  - Halt & PC_Sel in the same fire cycle -> HALT; Halted=1, PC_Hold=1, Redirect_Count unchanged.
  - Later PC_Sel pulses are ignored.
  - Async rst_n pulse mid-cycle returns to IDLE with outputs 0 immediately.
- Saturation: CNT_W=2, issue 5 accepted redirects -> count sequence 1, 2, 3, 3, 3.
